// File: rtl/xor_gate.sv
// ============================================================================
// Module      : xor_gate
// Description : Configurable-width bitwise XOR with parity and equality flags,
//               optionally registered for one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_gate #(
  parameter int WIDTH   = 32,
  parameter int REG_OUT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] s_o,
  output logic             par_o,
  output logic             eq_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] s_d;
  logic             par_d;
  logic             eq_d;

  // Plain operators keep X on an input bit visible on the matching result bit.
  assign s_d   = a_i ^ b_i;
  assign par_d = ^s_d;
  assign eq_d  = ~|s_d;

  generate
    if (REG_OUT == 0) begin : g_comb
      logic w_unused;
      assign w_unused = &{1'b0, clk_i, rst_i, en_i};

      assign s_o     = s_d;
      assign par_o   = par_d;
      assign eq_o    = eq_d;
      assign valid_o = 1'b1;
    end else begin : g_reg
      logic [WIDTH-1:0] s_q;
      logic             par_q;
      logic             eq_q;
      logic             valid_q;

      // Flags are captured alongside s so all three always describe one result.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s_q     <= '0;
          par_q   <= 1'b0;
          eq_q    <= 1'b0;
          valid_q <= 1'b0;
        end else if (en_i) begin
          s_q     <= s_d;
          par_q   <= par_d;
          eq_q    <= eq_d;
          valid_q <= 1'b1;
        end
      end

      assign s_o     = s_q;
      assign par_o   = par_q;
      assign eq_o    = eq_q;
      assign valid_o = valid_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_xor_gate.sv
// Self-checking bench for xor_gate: a combinational and a registered instance
// share stimulus; directed vectors, control sequences, then random traffic.
`default_nettype none

module tb_xor_gate;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;

  logic [W-1:0] c_s, r_s;
  logic         c_par, c_eq, c_valid;
  logic         r_par, r_eq, r_valid;

  int errors = 0;
  int checks = 0;

  // Reference state for the registered instance
  logic [W-1:0] m_s     = '0;
  logic         m_par   = 1'b0;
  logic         m_eq    = 1'b0;
  logic         m_valid = 1'b0;

  always #5 clk = ~clk;

  xor_gate #(.WIDTH(W), .REG_OUT(0)) dut_c (
    .clk_i(clk), .rst_i(rst), .en_i(en), .a_i(a), .b_i(b),
    .s_o(c_s), .par_o(c_par), .eq_o(c_eq), .valid_o(c_valid)
  );

  xor_gate #(.WIDTH(W), .REG_OUT(1)) dut_r (
    .clk_i(clk), .rst_i(rst), .en_i(en), .a_i(a), .b_i(b),
    .s_o(r_s), .par_o(r_par), .eq_o(r_eq), .valid_o(r_valid)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         par;
    logic         eq;
  } vec_t;

  // Per-bit difference count: parity is count mod 2, equality is count zero.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] ms, output logic mp, output logic me);
    int ones = 0;
    for (int i = 0; i < W; i++) begin
      ms[i] = (ma[i] != mb[i]);
      if (ma[i] != mb[i]) ones++;
    end
    mp = (ones % 2) == 1;
    me = (ones == 0);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_comb(input string tag, input logic [W-1:0] es, input logic ep, input logic ee);
    chk({tag, " comb s"}, c_s, es);
    chk({tag, " comb par"}, {31'd0, c_par}, {31'd0, ep});
    chk({tag, " comb eq"}, {31'd0, c_eq}, {31'd0, ee});
    chk({tag, " comb valid"}, {31'd0, c_valid}, 32'd1);
  endtask

  task automatic check_reg(input string tag);
    chk({tag, " reg s"}, r_s, m_s);
    chk({tag, " reg par"}, {31'd0, r_par}, {31'd0, m_par});
    chk({tag, " reg eq"}, {31'd0, r_eq}, {31'd0, m_eq});
    chk({tag, " reg valid"}, {31'd0, r_valid}, {31'd0, m_valid});
  endtask

  // Advance one edge, update the registered reference, check just after the edge.
  task automatic step(input string tag);
    logic [W-1:0] ns;
    logic np, ne;
    model(a, b, ns, np, ne);
    @(posedge clk);
    if (rst) begin
      m_s = '0; m_par = 1'b0; m_eq = 1'b0; m_valid = 1'b0;
    end else if (en) begin
      m_s = ns; m_par = np; m_eq = ne; m_valid = 1'b1;
    end
    #1;
    check_reg(tag);
  endtask

  task automatic drive(input logic [W-1:0] na, input logic [W-1:0] nb,
                       input logic nen, input logic nrst);
    @(negedge clk);
    a = na; b = nb; en = nen; rst = nrst;
    #1;
  endtask

  vec_t vecs[5];

  initial begin
    logic [W-1:0] es;
    logic ep, ee;

    vecs[0] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    vecs[1] = '{32'hffffffff, 32'h00000000, 32'hffffffff, 1'b0, 1'b0};
    vecs[2] = '{32'hffffffff, 32'hffff0000, 32'h0000ffff, 1'b0, 1'b0};
    vecs[3] = '{32'h12345678, 32'hffff0000, 32'hedcb5678, 1'b1, 1'b0};
    vecs[4] = '{32'h12345678, 32'hfedcba98, 32'hece8ece0, 1'b1, 1'b0};

    // Reset state
    drive(32'hdeadbeef, 32'h01234567, 1'b0, 1'b1);
    step("reset");

    // Directed vectors: combinational now, registered one edge later
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      check_comb($sformatf("vec%0d", i), vecs[i].s, vecs[i].par, vecs[i].eq);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d lag s", i), r_s, vecs[i].s);
    end

    // All-ones against itself
    drive(32'hffffffff, 32'hffffffff, 1'b1, 1'b0);
    check_comb("ones", 32'h0, 1'b0, 1'b1);
    step("ones");

    // Capture, then hold with en low while operands change
    drive(32'h12345678, 32'hfedcba98, 1'b1, 1'b0);
    step("capture");
    drive(32'hcafef00d, 32'h0badc0de, 1'b0, 1'b0);
    model(a, b, es, ep, ee);
    check_comb("hold", es, ep, ee);
    step("hold1");
    step("hold2");
    chk("hold value", r_s, 32'hece8ece0);

    // Single-edge reset discards captured data
    drive(32'hcafef00d, 32'h0badc0de, 1'b0, 1'b1);
    step("midreset");
    chk("midreset valid", {31'd0, r_valid}, 32'd0);

    // Recapture, then reset and enable together: reset wins
    drive(32'h0f0f0f0f, 32'h00ff00ff, 1'b1, 1'b0);
    step("recapture");
    drive(32'h11111111, 32'h22222222, 1'b1, 1'b1);
    step("rst_en");
    chk("rst_en s", r_s, 32'h0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
      drive(ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      model(a, b, es, ep, ee);
      check_comb("rand", es, ep, ee);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
